// File: rtl/owm_byte_seq_if.sv
// Purpose: command/response handshake plus sockit_owm register-bus bundle for owm_byte_seq.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready on commands; responses are single-cycle pulses with no backpressure.
interface owm_byte_seq_if #(
    parameter int BWD = 32
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [7:0]     cmd_data;
    logic           rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_presence;
    logic           rsp_err;
    logic           busy;
    logic           bus_ren;
    logic           bus_wen;
    logic           bus_adr;
    logic [BWD-1:0] bus_wdt;
    logic [BWD-1:0] bus_rdt;

    // Sequencer side: consumes commands and bus status, drives responses and the bus.
    modport master (
        input  cmd_valid, cmd_op, cmd_data, bus_rdt,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy,
               bus_ren, bus_wen, bus_adr, bus_wdt
    );

    // Environment side: command producer, response consumer and sockit_owm.
    modport slave (
        output cmd_valid, cmd_op, cmd_data, bus_rdt,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy,
               bus_ren, bus_wen, bus_adr, bus_wdt
    );
endinterface

// File: rtl/owm_byte_seq.sv
// Purpose: byte-level 1-wire command sequencer driving sockit_owm one bit slot at a time (optional slot timeout: OWM_SEQ_TIMEOUT_EN).
// Latency: 2 cycles + 3 cycles per bit + sockit_owm slot time; illegal op answers 2 cycles after accept.
// Backpressure: cmd_ready only in IDLE, commands offered while busy are dropped; rsp_valid is a 1-cycle pulse with no backpressure.
module owm_byte_seq #(
    parameter int BWD     = 32,
    parameter int TMO_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    owm_byte_seq_if.master io
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_RD  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    logic [2:0] state;
    logic [1:0] op_q;
    logic [7:0] data_q;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       armed;
    logic       presence;
    logic       slot_done;
    logic       last_slot;

`ifdef OWM_SEQ_TIMEOUT_EN
    logic [15:0] tmo;
`else
    logic [15:0] unused_tmo;
    assign unused_tmo = 16'(TMO_CYC);
`endif

    logic [BWD-3:0] unused_rdt;
    assign unused_rdt = {io.bus_rdt[BWD-1:4], io.bus_rdt[2:1]};

    // Control word for one slot: reset pulse, write slot carrying the bit, or write-1 slot for reads.
    function automatic logic [BWD-1:0] wdt_word(input logic [1:0] op, input logic bit_v);
        logic [7:0] b;
        case (op)
            OP_RST:  b = 8'h0A;
            OP_WR:   b = {7'b0000100, bit_v};
            default: b = 8'h09;
        endcase
        return {{(BWD-8){1'b0}}, b};
    endfunction

    assign io.bus_adr = 1'b0;
    // A slot is finished once CYC has been seen high and has dropped again.
    assign slot_done  = armed && !io.bus_rdt[3];
    // Reset and illegal ops are single-step; byte ops end after bit 7.
    assign last_slot  = (op_q == OP_RST) || (op_q == OP_ILL) || (bit_cnt == 3'd7);

    // Sequencer FSM; every output is registered and reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            io.cmd_ready    <= 1'b0;
            io.rsp_valid    <= 1'b0;
            io.rsp_data     <= 8'h00;
            io.rsp_presence <= 1'b0;
            io.rsp_err      <= 1'b0;
            io.busy         <= 1'b0;
            io.bus_ren      <= 1'b0;
            io.bus_wen      <= 1'b0;
            io.bus_wdt      <= '0;
            op_q            <= OP_RST;
            data_q          <= 8'h00;
            shreg           <= 8'h00;
            bit_cnt         <= 3'd0;
            armed           <= 1'b0;
            presence        <= 1'b0;
`ifdef OWM_SEQ_TIMEOUT_EN
            tmo             <= 16'd0;
`endif
        end else begin
            io.rsp_valid <= 1'b0;
            io.bus_wen   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io.cmd_valid && io.cmd_ready) begin
                        op_q         <= io.cmd_op;
                        data_q       <= io.cmd_data;
                        bit_cnt      <= 3'd0;
                        shreg        <= 8'h00;
                        presence     <= 1'b0;
                        io.cmd_ready <= 1'b0;
                        io.busy      <= 1'b1;
                        // Illegal ops skip the bus and are answered from NEXT.
                        if (io.cmd_op == OP_ILL) begin
                            state <= S_NEXT;
                        end else begin
                            state      <= S_ISSUE;
                            io.bus_wen <= 1'b1;
                            io.bus_wdt <= wdt_word(io.cmd_op, io.cmd_data[0]);
                        end
                    end else begin
                        io.cmd_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    armed      <= 1'b0;
`ifdef OWM_SEQ_TIMEOUT_EN
                    tmo        <= 16'(TMO_CYC);
`endif
                    io.bus_ren <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (io.bus_rdt[3]) begin
                        armed <= 1'b1;
                    end
                    // Completion wins over a timeout expiring in the same cycle.
                    if (slot_done) begin
                        if (op_q == OP_RST) presence <= ~io.bus_rdt[0];
                        if (op_q == OP_RD)  shreg    <= {io.bus_rdt[0], shreg[7:1]};
                        io.bus_ren <= 1'b0;
                        state      <= S_NEXT;
                    end
`ifdef OWM_SEQ_TIMEOUT_EN
                    else if (tmo == 16'd0) begin
                        io.bus_ren      <= 1'b0;
                        io.rsp_valid    <= 1'b1;
                        io.rsp_err      <= 1'b1;
                        io.rsp_data     <= 8'h00;
                        io.rsp_presence <= 1'b0;
                        state           <= S_RESP;
                    end else begin
                        tmo <= tmo - 16'd1;
                    end
`endif
                end
                S_NEXT: begin
                    if (last_slot) begin
                        io.rsp_valid    <= 1'b1;
                        io.rsp_data     <= (op_q == OP_RD) ? shreg : 8'h00;
                        io.rsp_presence <= (op_q == OP_RST) && presence;
                        io.rsp_err      <= (op_q == OP_ILL);
                        state           <= S_RESP;
                    end else begin
                        bit_cnt    <= bit_cnt + 3'd1;
                        io.bus_wen <= 1'b1;
                        io.bus_wdt <= wdt_word(op_q, data_q[bit_cnt + 3'd1]);
                        state      <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    io.rsp_data     <= 8'h00;
                    io.rsp_presence <= 1'b0;
                    io.rsp_err      <= 1'b0;
                    io.busy         <= 1'b0;
                    io.cmd_ready    <= 1'b1;
                    state           <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_owm_byte_seq.sv
// Purpose: self-checking bench for owm_byte_seq with a small sockit_owm slot model.
// Latency: model slot holds CYC high 3 cycles after each bus_wen, so each bit costs 6 cycles.
// Backpressure: commands wait for cmd_ready; responses are captured in their pulse cycle.
module tb_owm_byte_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    owm_byte_seq_if #(.BWD(32)) ifc ();
    owm_byte_seq #(.BWD(32), .TMO_CYC(100)) dut (.clk(clk), .rst(rst), .io(ifc.master));

    int n_chk  = 0;
    int n_pass = 0;

    // sockit_owm stand-in: CYC rises after a write, falls 3 cycles later with DAT = rd_bits[slot]
    logic       model_on = 1'b1;
    logic [7:0] rd_bits  = 8'h00;
    logic       cyc      = 1'b0;
    logic       dat      = 1'b1;
    int         cnt      = 0;
    int         cur_slot = 0;
    int         base     = 0;
    logic [7:0] wen_log[$];

    assign ifc.bus_rdt = {28'h0, cyc, 2'b00, dat};

    always @(posedge clk) begin
        if (ifc.bus_wen) begin
            cur_slot <= wen_log.size() - base;
            wen_log.push_back(ifc.bus_wdt[7:0]);
            if (model_on) begin
                cyc <= 1'b1;
                cnt <= 3;
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                cyc <= 1'b0;
                dat <= (cur_slot < 8) ? rd_bits[cur_slot[2:0]] : 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Offer one command at the next free slot, then watch up to budget cycles for the response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input int budget,
                           output int lat, output logic [7:0] rdata, output logic pres, output logic err);
        int w;
        w = 0;
        while (!ifc.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", 32'(ifc.cmd_ready), 32'd1);
        base = wen_log.size();
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        lat = -1; rdata = 8'h00; pres = 1'b0; err = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (ifc.rsp_valid) begin
                lat = k; rdata = ifc.rsp_data; pres = ifc.rsp_presence; err = ifc.rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  din;
        logic [7:0]  rd;
        int          exp_lat;
        logic [7:0]  exp_data;
        logic        exp_pres;
        logic        exp_err;
        int          exp_nwen;
        logic [63:0] exp_wdt;   // slot j control byte at [8*j +: 8]
    } vec_t;

    vec_t vt[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] rdata;
        logic pres, err;
        int n;
        logic seen;

        vt[0] = '{2'd0, 8'h00, 8'h00,  7, 8'h00, 1'b1, 1'b0, 1, 64'h0A};
        vt[1] = '{2'd0, 8'h00, 8'hFF,  7, 8'h00, 1'b0, 1'b0, 1, 64'h0A};
        vt[2] = '{2'd1, 8'hCC, 8'hFF, 49, 8'h00, 1'b0, 1'b0, 8, 64'h0909080809090808};
        vt[3] = '{2'd1, 8'hA5, 8'h00, 49, 8'h00, 1'b0, 1'b0, 8, 64'h0908090808090809};
        vt[4] = '{2'd2, 8'h00, 8'h85, 49, 8'h85, 1'b0, 1'b0, 8, 64'h0909090909090909};
        vt[5] = '{2'd2, 8'hFF, 8'h3C, 49, 8'h3C, 1'b0, 1'b0, 8, 64'h0909090909090909};
        vt[6] = '{2'd3, 8'h5A, 8'h00,  2, 8'h00, 1'b0, 1'b1, 0, 64'h0};

        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'd0;
        ifc.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        chk("rst_busy",      32'(ifc.busy),      32'd0);
        chk("rst_rsp",       32'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_presence, ifc.rsp_data}), 32'd0);
        chk("rst_bus",       32'({ifc.bus_ren, ifc.bus_wen, ifc.bus_adr}), 32'd0);
        chk("rst_wdt",       ifc.bus_wdt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(ifc.cmd_ready), 32'd1);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            rd_bits = vt[i].rd;
            run_cmd(vt[i].op, vt[i].din, 200, lat, rdata, pres, err);
            chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_data", i), 32'(rdata), 32'(vt[i].exp_data));
            chk($sformatf("v%0d_pres", i), 32'(pres), 32'(vt[i].exp_pres));
            chk($sformatf("v%0d_err", i),  32'(err), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_nwen", i), 32'(wen_log.size() - base), 32'(vt[i].exp_nwen));
            for (int j = 0; j < vt[i].exp_nwen && (base + j) < wen_log.size(); j++)
                chk($sformatf("v%0d_wdt%0d", i, j), 32'(wen_log[base + j]), 32'(vt[i].exp_wdt[8*j +: 8]));
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), 32'(ifc.rsp_valid), 32'd0);
            chk($sformatf("v%0d_ready_back", i), 32'(ifc.cmd_ready), 32'd1);
        end
        chk("wdt_hold", ifc.bus_wdt, 32'h09);

        // Illegal op: cmd_ready must drop at accept and no bus write appears
        base = wen_log.size();
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'd3; ifc.cmd_data = 8'h00;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        chk("ill_ready_drop", 32'({ifc.cmd_ready, ifc.busy, ifc.bus_wen, ifc.rsp_valid}), 32'b0100);
        @(negedge clk);
        chk("ill_rsp", 32'({ifc.rsp_valid, ifc.rsp_err, ifc.bus_wen}), 32'b110);
        @(negedge clk);
        chk("ill_ready", 32'({ifc.cmd_ready, ifc.busy}), 32'b10);
        chk("ill_nwen", 32'(wen_log.size() - base), 32'd0);

        // Slot never completes
        model_on = 1'b0;
        run_cmd(2'd1, 8'h55, 200, lat, rdata, pres, err);
`ifdef OWM_SEQ_TIMEOUT_EN
        chk("tmo_in_time", 32'(lat >= 2 && lat <= 104), 32'd1);
        chk("tmo_rsp", 32'({err, pres, rdata}), 32'h200);
        chk("tmo_nwen", 32'(wen_log.size() - base), 32'd1);
`else
        chk("notmo_no_rsp", 32'(lat), 32'hFFFF_FFFF);
        chk("notmo_busy", 32'({ifc.busy, ifc.bus_ren}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        model_on = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during bit 4 of a write, then a normal detect
        rd_bits = 8'hFF;
        base = wen_log.size();
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'd1; ifc.cmd_data = 8'hCC;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && n < 5; k++) begin
            if (ifc.bus_wen) n++;
            if (n < 5) @(negedge clk);
        end
        chk("mid_reach_bit4", 32'(n), 32'd5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'({ifc.busy, ifc.bus_ren, ifc.rsp_valid, ifc.bus_wen}), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ifc.rsp_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        rd_bits = 8'h00;
        run_cmd(2'd0, 8'h00, 200, lat, rdata, pres, err);
        chk("post_detect_lat", 32'(lat), 32'd7);
        chk("post_detect_rsp", 32'({err, pres, rdata}), 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
